kssub4b_serial: RTL and testbench

Bit-serial 4-bit subtractor with borrow-in. It computes S = K − T − bin one bit per clock, LSB first, through a single full-subtractor cell, and returns a 4-bit difference plus borrow-out. It is the subtract-direction companion to the team's 4-bit adder. It sits beside the adder in the arithmetic datapath, where area matters more than latency. It uses the same scalar-bit operand convention as the adder, with a start/busy/done handshake.

---
 rtl/kssub4b_pkg.sv | 16 +
 rtl/cmos_and.sv | 10 +
 rtl/cmos_inverter.sv | 9 +
 rtl/cmos_xor.sv | 10 +
 rtl/fsub1b.sv | 37 +++
 rtl/kssub4b_serial.sv | 110 +++++++++++
 tb/tb_kssub4b_serial.sv | 226 ++++++++++++++++++++++
 7 files changed

// File: rtl/kssub4b_pkg.sv
// rtl/kssub4b_pkg.sv - shared constants and state encoding for the serial 4-bit subtractor
package kssub4b_pkg;

  localparam int W  = 4;
  localparam int CW = 2;

  // Counter value of the final bit slot; reaching it ends the SHIFT phase.
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/cmos_and.sv
// rtl/cmos_and.sv - two-input AND primitive
module cmos_and (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/cmos_inverter.sv
// rtl/cmos_inverter.sv - single-input inverter primitive
module cmos_inverter (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

// File: rtl/cmos_xor.sv
// rtl/cmos_xor.sv - two-input XOR primitive
module cmos_xor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/fsub1b.sv
// rtl/fsub1b.sv - combinational full-subtractor cell built from gate primitives
module fsub1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;
  logic na;
  logic naxb;
  logic gen;
  logic prop;
  logic ngen;
  logic nprop;
  logic nbout;

  // Difference: a ^ b ^ bin
  cmos_xor      u_x1 (.a(a),   .b(b),   .y(axb));
  cmos_xor      u_x2 (.a(axb), .b(bin), .y(d));

  // Borrow generated when a=0, b=1
  cmos_inverter u_na (.a(a),   .y(na));
  cmos_and      u_g  (.a(na),  .b(b),   .y(gen));

  // Borrow propagated when a==b and a borrow came in
  cmos_inverter u_nx (.a(axb), .y(naxb));
  cmos_and      u_p  (.a(naxb), .b(bin), .y(prop));

  // OR of generate and propagate, formed as NAND of the inverted terms
  cmos_inverter u_ng (.a(gen),  .y(ngen));
  cmos_inverter u_np (.a(prop), .y(nprop));
  cmos_and      u_o  (.a(ngen), .b(nprop), .y(nbout));
  cmos_inverter u_ob (.a(nbout), .y(bout));

endmodule

// File: rtl/kssub4b_serial.sv
// rtl/kssub4b_serial.sv - bit-serial 4-bit subtractor K - T - bin; optional z flag via KSSUB4B_ZFLAG_EN
module kssub4b_serial
  import kssub4b_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic k0,
  input  logic k1,
  input  logic k2,
  input  logic k3,
  input  logic t0,
  input  logic t1,
  input  logic t2,
  input  logic t3,
  input  logic bin,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic busy,
  output logic done
`ifdef KSSUB4B_ZFLAG_EN
  ,
  output logic z
`endif
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  kreg;
  logic [W-1:0]  treg;
  logic          brw;
  logic [W-1:0]  shadow;
  logic [W:0]    res;
  logic          cell_d;
  logic          cell_bout;
`ifdef KSSUB4B_ZFLAG_EN
  logic          zreg;
`endif

  // The one shared cell always works on the current LSB of the operand shift registers.
  fsub1b u_cell (
    .a    (kreg[0]),
    .b    (treg[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Sequencer: capture operands, shift one bit per cycle, publish the result atomically on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      kreg   <= '0;
      treg   <= '0;
      brw    <= 1'b0;
      shadow <= '0;
      res    <= '0;
`ifdef KSSUB4B_ZFLAG_EN
      zreg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            kreg  <= {k3, k2, k1, k0};
            treg  <= {t3, t2, t1, t0};
            brw   <= bin;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          kreg   <= kreg >> 1;
          treg   <= treg >> 1;
          brw    <= cell_bout;
          // Bits enter at the MSB so that after W shifts bit 0 sits at shadow[0].
          shadow <= {cell_d, shadow[W-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // The last bit goes straight to the outputs instead of waiting for another shift.
            res   <= {cell_bout, cell_d, shadow[W-1:1]};
`ifdef KSSUB4B_ZFLAG_EN
            zreg  <= ({cell_d, shadow[W-1:1]} == '0);
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s0   = res[0];
  assign s1   = res[1];
  assign s2   = res[2];
  assign s3   = res[3];
  assign s4   = res[4];
  assign busy = (state == SHIFT);
  assign done = (state == DONE);
`ifdef KSSUB4B_ZFLAG_EN
  assign z    = zreg;
`endif

endmodule

// File: tb/tb_kssub4b_serial.sv
// tb/tb_kssub4b_serial.sv - directed-vector bench for kssub4b_serial
module tb_kssub4b_serial;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic k0 = 1'b0, k1 = 1'b0, k2 = 1'b0, k3 = 1'b0;
  logic t0 = 1'b0, t1 = 1'b0, t2 = 1'b0, t3 = 1'b0;
  logic bin = 1'b0;
  logic s0, s1, s2, s3, s4, busy, done;
`ifdef KSSUB4B_ZFLAG_EN
  logic z;
`endif
  logic [4:0] s_vec;

  int vecs = 0;
  int errs = 0;

  kssub4b_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .k0    (k0),
    .k1    (k1),
    .k2    (k2),
    .k3    (k3),
    .t0    (t0),
    .t1    (t1),
    .t2    (t2),
    .t3    (t3),
    .bin   (bin),
    .s0    (s0),
    .s1    (s1),
    .s2    (s2),
    .s3    (s3),
    .s4    (s4),
    .busy  (busy),
    .done  (done)
`ifdef KSSUB4B_ZFLAG_EN
    ,
    .z     (z)
`endif
  );

  assign s_vec = {s4, s3, s2, s1, s0};

  always #5 clk = ~clk;

  // Drive one start pulse; returns at the negedge of the cycle after the accepting edge.
  task automatic drive_start(input logic [3:0] kv, input logic [3:0] tv, input logic bv);
    @(negedge clk);
    {k3, k2, k1, k0} = kv;
    {t3, t2, t1, t0} = tv;
    bin = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    {k3, k2, k1, k0} = ~kv;
    {t3, t2, t1, t0} = ~tv;
    bin = ~bv;
  endtask

  // Count negedges until done is seen; -1 if the budget runs out.
  task automatic wait_done(input int maxc, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (n < maxc && !found) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  // Count done pulses seen over a number of cycles.
  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if (s_vec !== 5'b00000) begin errs++; $display("FAIL reset_s got=%b exp=%b", s_vec, 5'b00000); end
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef KSSUB4B_ZFLAG_EN
    vecs++;
    if (z !== 1'b0) begin errs++; $display("FAIL reset_z got=%b exp=0", z); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_vector(input string name, input logic [3:0] kv, input logic [3:0] tv,
                             input logic bv, input logic [3:0] exp_d, input logic exp_b);
    int n;
    drive_start(kv, tv, bv);
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
    wait_done(8, n);
    vecs++;
    if (n !== 4) begin errs++; $display("FAIL %s_latency got=%0d exp=4", name, n); end
    vecs++;
    if (s_vec[3:0] !== exp_d) begin errs++; $display("FAIL %s_diff got=%b exp=%b", name, s_vec[3:0], exp_d); end
    vecs++;
    if (s4 !== exp_b) begin errs++; $display("FAIL %s_borrow got=%b exp=%b", name, s4, exp_b); end
`ifdef KSSUB4B_ZFLAG_EN
    vecs++;
    if (z !== (exp_d == 4'b0000)) begin errs++; $display("FAIL %s_z got=%b exp=%b", name, z, exp_d == 4'b0000); end
`endif
    @(negedge clk);
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL %s_done_width got=%b exp=0", name, done); end
  endtask

  task automatic test_ignore_start;
    int n;
    drive_start(4'd15, 4'd1, 1'b0);
    @(negedge clk);
    {k3, k2, k1, k0} = 4'd0;
    {t3, t2, t1, t0} = 4'd7;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(8, n);
    vecs++;
    if (n !== 2) begin errs++; $display("FAIL ignore_latency got=%0d exp=2", n); end
    vecs++;
    if (s_vec !== 5'b01110) begin errs++; $display("FAIL ignore_result got=%b exp=%b", s_vec, 5'b01110); end
    count_dones(10, n);
    vecs++;
    if (n !== 0) begin errs++; $display("FAIL ignore_extra_done got=%0d exp=0", n); end
  endtask

  task automatic test_reset_mid;
    int n;
    drive_start(4'd8, 4'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    vecs++;
    if (done !== 1'b0) begin errs++; $display("FAIL rstmid_done got=%b exp=0", done); end
    vecs++;
    if (s_vec !== 5'b00000) begin errs++; $display("FAIL rstmid_s got=%b exp=%b", s_vec, 5'b00000); end
    count_dones(10, n);
    vecs++;
    if (n !== 0) begin errs++; $display("FAIL rstmid_done_count got=%0d exp=0", n); end
  endtask

  task automatic test_rst_and_start;
    int n;
    @(negedge clk);
    {k3, k2, k1, k0} = 4'd9;
    {t3, t2, t1, t0} = 4'd3;
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL rststart_busy got=%b exp=0", busy); end
    count_dones(8, n);
    vecs++;
    if (n !== 0) begin errs++; $display("FAIL rststart_done_count got=%0d exp=0", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    drive_start(4'd4, 4'd1, 1'b0);
    wait_done(8, n);
    vecs++;
    if (n !== 4) begin errs++; $display("FAIL b2b_first_latency got=%0d exp=4", n); end
    vecs++;
    if (s_vec !== 5'b00011) begin errs++; $display("FAIL b2b_first_result got=%b exp=%b", s_vec, 5'b00011); end
    {k3, k2, k1, k0} = 4'd1;
    {t3, t2, t1, t0} = 4'd4;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL b2b_restart got busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    vecs++;
    if (s_vec !== 5'b00011) begin errs++; $display("FAIL b2b_hold1 got=%b exp=%b", s_vec, 5'b00011); end
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if (s_vec !== 5'b00011) begin errs++; $display("FAIL b2b_hold2 got=%b exp=%b", s_vec, 5'b00011); end
    wait_done(8, n);
    vecs++;
    if (n !== 2) begin errs++; $display("FAIL b2b_second_latency got=%0d exp=2", n); end
    vecs++;
    if (s_vec !== 5'b11101) begin errs++; $display("FAIL b2b_second_result got=%b exp=%b", s_vec, 5'b11101); end
  endtask

  initial begin
    test_reset();
    test_vector("k9t3",  4'd9, 4'd3, 1'b0, 4'b0110, 1'b0);
    test_vector("k3t9",  4'd3, 4'd9, 1'b0, 4'b1010, 1'b1);
    test_vector("k0t0b", 4'd0, 4'd0, 1'b1, 4'b1111, 1'b1);
    test_vector("k5t5",  4'd5, 4'd5, 1'b0, 4'b0000, 1'b0);
    test_ignore_start();
    test_reset_mid();
    test_rst_and_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
